sonic_ranger: RTL and testbench

Ranging controller for the HC-SR04 ultrasonic sensor on sensor port 1. It drives `s1_trig`, times the `s1_echo` pulse on the 1 MHz tick clock, and converts the echo width to centimetres. Each result is delivered as a one-cycle valid pulse to the UART/HMI logic inside `top`. It sits directly between the top-level sensor pins and the register and UART path.

---
 rtl/sonic_ranger_pkg.sv | 24 ++
 rtl/sonic_ranger_if.sv | 29 ++
 rtl/sonic_ranger_div.sv | 47 ++++
 rtl/sonic_ranger.sv | 148 ++++++++++++++
 tb/tb_sonic_ranger.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/sonic_ranger_pkg.sv
// sonic_pkg: shared types and constants for the HC-SR04 ranging controller.
// Contents: FSM state enum, error codes, the cm conversion constant and the
// counter/result widths used by sonic_ranger, sonic_div and sonic_ranger_if.
package sonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DIV,
        HOLD
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NO_ECHO = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;

    localparam int unsigned US_PER_CM = 58;
    localparam int unsigned CNT_W     = 17;
    localparam int unsigned WIDTH_W   = 15;
    localparam int unsigned DIST_W    = 9;

endpackage

// File: rtl/sonic_ranger_if.sv
// sonic_ranger_if: request/result bus between the ranging controller and the
// register/UART logic.
//   start    : one-cycle measurement request (master -> slave)
//   busy     : controller not idle
//   dist_cm  : last good distance in cm, valid with and held after dist_vld
//   dist_vld : one-cycle pulse on a new distance
//   err_vld  : one-cycle pulse on a failed measurement
//   err_code : 01 no echo, 10 over range; held until the next err_vld
interface sonic_ranger_if;
    import sonic_pkg::*;

    logic              start;
    logic              busy;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_vld;
    logic              err_vld;
    logic [1:0]        err_code;

    modport master (
        output start,
        input  busy, dist_cm, dist_vld, err_vld, err_code
    );

    modport slave (
        input  start,
        output busy, dist_cm, dist_vld, err_vld, err_code
    );

endinterface

// File: rtl/sonic_ranger_div.sv
// sonic_div: divides a 15-bit echo width by US_PER_CM using one subtraction
// per cycle.
//   clk_1m, rst_n : clock, asynchronous active-low reset
//   go            : loads num and starts the division
//   num           : echo width in us
//   done          : combinational, high in the final cycle of a division
//   quo           : floor(num / US_PER_CM), valid while done is high
module sonic_div
    import sonic_pkg::*;
(
    input  logic               clk_1m,
    input  logic               rst_n,
    input  logic               go,
    input  logic [WIDTH_W-1:0] num,
    output logic               done,
    output logic [DIST_W-1:0]  quo
);

    localparam logic [WIDTH_W-1:0] DIVISOR = WIDTH_W'(US_PER_CM);

    logic [WIDTH_W-1:0] rem;
    logic               run;

    // The cycle in which the remainder first drops below the divisor is the
    // last one, so a division takes floor(num/58)+1 cycles after go.
    assign done = run && (rem < DIVISOR);

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            run <= 1'b0;
        end else if (go) begin
            rem <= num;
            quo <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (rem >= DIVISOR) begin
                rem <= rem - DIVISOR;
                quo <= quo + 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sonic_ranger.sv
// sonic_ranger: HC-SR04 ranging controller on sensor port 1, clocked at 1 MHz.
//   clk_1m  : 1 MHz clock (1 cycle = 1 us)
//   rst_n   : asynchronous active-low reset
//   s1_echo : raw asynchronous echo from the sensor
//   s1_trig : trigger pulse to the sensor
//   bus     : sonic_ranger_if.slave (start, busy, dist_cm/dist_vld,
//             err_vld/err_code)
// Optional feature: define SONIC_AUTO_EN to issue an internal start every
// PERIOD_US cycles from reset release (dropped while busy).
module sonic_ranger
    import sonic_pkg::*;
#(
    parameter int unsigned TRIG_US      = 10,
    parameter int unsigned ECHO_WAIT_US = 30000,
    parameter int unsigned ECHO_MAX_US  = 25000,
    parameter int unsigned HOLDOFF_US   = 60000,
    parameter int unsigned PERIOD_US    = 100000
) (
    input  logic            clk_1m,
    input  logic            rst_n,
    input  logic            s1_echo,
    output logic            s1_trig,
    sonic_ranger_if.slave   bus
);

    if (TRIG_US == 0 || ECHO_WAIT_US == 0 || HOLDOFF_US == 0 || PERIOD_US == 0 ||
        ECHO_MAX_US == 0 || ECHO_MAX_US >= (1 << WIDTH_W) ||
        ECHO_WAIT_US > (1 << CNT_W) || HOLDOFF_US > (1 << CNT_W)) begin : g_bad_param
        $error("sonic_ranger: parameter out of range");
    end

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               echo_m, echo_s, echo_d;
    logic               rise, fall;
    logic               req;
    logic               trig_q;
    logic               div_go, div_done;
    logic [DIST_W-1:0]  div_quo;
    logic [DIST_W-1:0]  dist_q;
    logic [1:0]         err_q;
    logic               dvld, evld;
    logic [1:0]         ecode;

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

`ifdef SONIC_AUTO_EN
    localparam int unsigned PER_W = $clog2(PERIOD_US + 1);
    logic [PER_W-1:0] per_cnt;
    logic             auto_start;

    assign auto_start = (per_cnt == PER_W'(PERIOD_US - 1));

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n)          per_cnt <= '0;
        else if (auto_start) per_cnt <= '0;
        else                 per_cnt <= per_cnt + 1'b1;
    end

    assign req = bus.start | auto_start;
`else
    assign req = bus.start;
`endif

    // cnt at the falling edge holds one less than the number of echo-high
    // samples (the rising sample was taken in WAIT_RISE), hence cnt + 1.
    sonic_div u_div (
        .clk_1m (clk_1m),
        .rst_n  (rst_n),
        .go     (div_go),
        .num    (WIDTH_W'(cnt + 1'b1)),
        .done   (div_done),
        .quo    (div_quo)
    );

    always_comb begin
        state_n = state_q;
        div_go  = 1'b0;
        dvld    = 1'b0;
        evld    = 1'b0;
        ecode   = ERR_NONE;
        case (state_q)
            IDLE:      if (req) state_n = TRIG;
            TRIG:      if (cnt == CNT_W'(TRIG_US - 1)) state_n = WAIT_RISE;
            WAIT_RISE: begin
                if (rise) begin
                    state_n = MEASURE;
                end else if (cnt == CNT_W'(ECHO_WAIT_US - 1)) begin
                    evld    = 1'b1;
                    ecode   = ERR_NO_ECHO;
                    state_n = HOLD;
                end
            end
            MEASURE: begin
                if (fall) begin
                    div_go  = 1'b1;
                    state_n = DIV;
                end else if (echo_s && cnt == CNT_W'(ECHO_MAX_US - 1)) begin
                    evld    = 1'b1;
                    ecode   = ERR_RANGE;
                    state_n = HOLD;
                end
            end
            DIV: begin
                if (div_done) begin
                    dvld    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD:      if (cnt == CNT_W'(HOLDOFF_US - 1)) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt     <= '0;
            trig_q  <= 1'b0;
            echo_m  <= 1'b0;
            echo_s  <= 1'b0;
            echo_d  <= 1'b0;
            dist_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_n;
            if (state_n != state_q || state_q == IDLE) cnt <= '0;
            else                                       cnt <= cnt + 1'b1;
            trig_q  <= (state_n == TRIG);
            echo_m  <= s1_echo;
            echo_s  <= echo_m;
            echo_d  <= echo_s;
            if (dvld) dist_q <= div_quo;
            if (evld) err_q  <= ecode;
        end
    end

    // Results are presented in the cycle they are produced; the registers
    // keep them visible afterwards.
    assign s1_trig      = trig_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.dist_vld = dvld;
    assign bus.dist_cm  = dvld ? div_quo : dist_q;
    assign bus.err_vld  = evld;
    assign bus.err_code = evld ? ecode : err_q;

endmodule

// File: tb/tb_sonic_ranger.sv
// tb_sonic_ranger: directed self-checking bench for sonic_ranger.
// Short wait/holdoff parameters keep the run brief; echo widths are exact.
`timescale 1ns/1ps
module tb_sonic_ranger;
    import sonic_pkg::*;

    localparam int TRIG  = 10;
    localparam int WAITT = 500;
    localparam int HOLDT = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic s1_echo;
    logic s1_trig;
    sonic_ranger_if bus();

    always #5 clk = ~clk;

    sonic_ranger #(
        .TRIG_US      (TRIG),
        .ECHO_WAIT_US (WAITT),
        .ECHO_MAX_US  (25000),
        .HOLDOFF_US   (HOLDT),
        .PERIOD_US    (100000)
    ) dut (
        .clk_1m  (clk),
        .rst_n   (rst_n),
        .s1_echo (s1_echo),
        .s1_trig (s1_trig),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation monitor: counts pulses and stamps events.
    int trig_n = 0, dvld_n = 0, evld_n = 0, both_n = 0;
    int last_dist = 0, last_code = 0, evt_cyc = 0, fall_cyc = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (s1_trig) trig_n <= trig_n + 1;
        if (bus.dist_vld) begin
            dvld_n    <= dvld_n + 1;
            last_dist <= int'(bus.dist_cm);
            evt_cyc   <= cyc;
        end
        if (bus.err_vld) begin
            evld_n    <= evld_n + 1;
            last_code <= int'(bus.err_code);
            evt_cyc   <= cyc;
        end
        if (bus.dist_vld && bus.err_vld) both_n <= both_n + 1;
        if (busy_prev && !bus.busy) fall_cyc <= cyc;
        busy_prev <= bus.busy;
    end

    // One measurement: width 0 = no echo. Echo rises 100 cycles after trigger.
    task automatic do_meas(input string tag, input int width, input bit mid_start,
                           input int exp_dist, input int exp_dvld, input int exp_code);
        int t0, d0, e0, start_cyc;
        t0 = trig_n; d0 = dvld_n; e0 = evld_n;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        start_cyc = cyc;
        repeat (TRIG + 2 + 100) @(posedge clk);
        if (width > 0) begin
            #1 s1_echo = 1'b1;
            for (int i = 0; i < width; i++) begin
                @(posedge clk); #1;
                bus.start = (mid_start && i == width / 2);
            end
            s1_echo   = 1'b0;
            bus.start = 1'b0;
        end
        for (int i = 0; i < 2000; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check({tag, "_idle"}, int'(bus.busy), 0);
        check({tag, "_trig_w"}, trig_n - t0, TRIG);
        check({tag, "_dvld_n"}, dvld_n - d0, exp_dvld);
        check({tag, "_evld_n"}, evld_n - e0, 1 - exp_dvld);
        if (exp_dvld == 1) check({tag, "_dist_at_vld"}, last_dist, exp_dist);
        else               check({tag, "_code"}, last_code, exp_code);
        check({tag, "_dist_hold"}, int'(bus.dist_cm), exp_dist);
        check({tag, "_holdoff"}, fall_cyc - evt_cyc, HOLDT + 1);
        if (width == 0) check({tag, "_timeout"}, evt_cyc - start_cyc, TRIG + WAITT - 1);
    endtask

    initial begin
        rst_n = 1'b1;
        s1_echo = 1'b0;
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 s1_echo = ~s1_echo;
            @(negedge clk);
            check("rst_ctl", int'({s1_trig, bus.busy, bus.dist_vld, bus.err_vld}), 0);
        end
        check("rst_dist", int'(bus.dist_cm), 0);
        check("rst_code", int'(bus.err_code), 0);
        @(posedge clk); #1 s1_echo = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        do_meas("m580",   580,   1'b0, 10,  1, 0);
        do_meas("noecho", 0,     1'b0, 10,  0, 1);
        do_meas("m57",    57,    1'b0, 0,   1, 0);
        do_meas("m24940", 24940, 1'b0, 430, 1, 0);
        do_meas("range",  26000, 1'b0, 430, 0, 2);
        do_meas("midst",  580,   1'b1, 10,  1, 0);

        // Reset during TRIG drops the trigger immediately.
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstt_trig", int'(s1_trig), 0);
        check("rstt_busy", int'(bus.busy), 0);
        check("rstt_dist", int'(bus.dist_cm), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_meas("post_rst", 1160, 1'b0, 20, 1, 0);

        check("excl", both_n, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
